// File: rtl/bcd_timer_ctrl_if.sv
// Command and readout bundle between a host/button front end and the BCD timer.
interface bcd_timer_ctrl_if #(
   parameter int DIGITS = 4
);
   logic                start;
   logic                pause;
   logic                clear;
   logic                load;
   logic                dir;
   logic [4*DIGITS-1:0] load_value;
   logic [4*DIGITS-1:0] dout;
   logic                busy;
   logic                done;
   logic                tc;

   modport master (
      output start, pause, clear, load, dir, load_value,
      input  dout, busy, done, tc
   );

   modport slave (
      input  start, pause, clear, load, dir, load_value,
      output dout, busy, done, tc
   );
endinterface

// File: rtl/bcd_timer_ctrl.sv
// Start/pause/clear timer around a cascaded BCD counter with prescaled steps,
// preset load and terminal-count detection.
//
// state  | meaning
// IDLE   | stopped, count may be preset, direction latched on start
// RUN    | prescaler running, count steps every PRESCALE cycles
// PAUSED | frozen; prescaler and direction kept for resume
// DONE   | terminal value reached; only clear or reset leave
module bcd_timer_ctrl #(
   parameter int DIGITS   = 4,
   parameter int PRESCALE = 10
) (
   input logic              clock,
   input logic              reset,
   bcd_timer_ctrl_if.slave  bus
);
   localparam int W  = 4 * DIGITS;
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PSC_LAST = PW'(PRESCALE - 1);
   localparam logic [W-1:0]  NINES    = {DIGITS{4'd9}};

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_DONE} state_t;

   state_t         state, state_nxt;
   logic [W-1:0]   dout_q, dout_nxt;
   logic [PW-1:0]  psc, psc_nxt;
   logic           dir_q, dir_nxt;
   logic           tc_nxt, busy_nxt, done_nxt;
   logic           busy_q, done_q, tc_q;
   logic [W-1:0]   step_val;

   function automatic logic [W-1:0] sat_bcd(input logic [W-1:0] v);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < DIGITS; i++)
         r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
      return r;
   endfunction

   // Whole carry/borrow chain resolves in one pass so a step is one edge.
   function automatic logic [W-1:0] bcd_step(input logic [W-1:0] v, input logic up);
      logic [W-1:0] r;
      logic [3:0]   d;
      logic         c;
      r = '0;
      c = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         d = v[4*i +: 4];
         if (c) begin
            if (up) begin
               if (d == 4'd9) d = 4'd0;
               else begin d = d + 4'd1; c = 1'b0; end
            end else begin
               if (d == 4'd0) d = 4'd9;
               else begin d = d - 4'd1; c = 1'b0; end
            end
         end
         r[4*i +: 4] = d;
      end
      return r;
   endfunction

   function automatic logic [W-1:0] term(input logic up);
      return up ? NINES : '0;
   endfunction

   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= S_IDLE;
         dout_q <= '0;
         psc    <= '0;
         dir_q  <= 1'b1;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         tc_q   <= 1'b0;
      end else begin
         state  <= state_nxt;
         dout_q <= dout_nxt;
         psc    <= psc_nxt;
         dir_q  <= dir_nxt;
         busy_q <= busy_nxt;
         done_q <= done_nxt;
         tc_q   <= tc_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      dout_nxt  = dout_q;
      psc_nxt   = psc;
      dir_nxt   = dir_q;
      tc_nxt    = 1'b0;
      step_val  = bcd_step(dout_q, dir_q);
      if (bus.clear) begin
         state_nxt = S_IDLE;
         dout_nxt  = '0;
         psc_nxt   = '0;
      end else begin
         if (state == S_RUN) begin
            if (psc == PSC_LAST) begin
               psc_nxt  = '0;
               dout_nxt = step_val;
               if (step_val == term(dir_q)) begin
                  state_nxt = S_DONE;
                  tc_nxt    = 1'b1;
               end
            end else begin
               psc_nxt = psc + 1'b1;
            end
         end
         // Commands are gated on the state held during this cycle.
         if (bus.load) begin
            if (state == S_IDLE || state == S_PAUSED) begin
               dout_nxt = sat_bcd(bus.load_value);
               psc_nxt  = '0;
            end
         end else if (bus.start) begin
            if (state == S_IDLE) begin
               dir_nxt = bus.dir;
               psc_nxt = '0;
               if (dout_q == term(bus.dir)) begin
                  state_nxt = S_DONE;
                  tc_nxt    = 1'b1;
               end else begin
                  state_nxt = S_RUN;
               end
            end else if (state == S_PAUSED) begin
               if (dout_q == term(dir_q)) begin
                  state_nxt = S_DONE;
                  tc_nxt    = 1'b1;
                  psc_nxt   = '0;
               end else begin
                  state_nxt = S_RUN;
               end
            end
         end else if (bus.pause && state == S_RUN) begin
            // A terminal step coinciding with pause parks in PAUSED without tc.
            state_nxt = S_PAUSED;
            tc_nxt    = 1'b0;
         end
      end
   end

   always_comb begin
      busy_nxt = (state_nxt == S_RUN);
      done_nxt = (state_nxt == S_DONE);
   end

   assign bus.dout = dout_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.tc   = tc_q;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Directed scenarios plus randomized commands against an integer-count reference model.
module tb_bcd_timer_ctrl;
   localparam int D    = 4;
   localparam int P    = 4;
   localparam int MODV = 10 ** D;
   localparam int MI = 0, MR = 1, MP = 2, MD = 3;

   logic clock;
   logic reset;

   bcd_timer_ctrl_if #(.DIGITS(D)) bus ();

   bcd_timer_ctrl #(.DIGITS(D), .PRESCALE(P)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int n_checks = 0;
   int n_errors = 0;

   int m_cnt = 0;
   int m_psc = 0;
   int m_st  = MI;
   bit m_up  = 1'b1;
   bit m_tc  = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int sat_val(input logic [4*D-1:0] v);
      int r = 0;
      int w = 1;
      for (int i = 0; i < D; i++) begin
         int dg;
         dg = int'(v[4*i +: 4]);
         if (dg > 9) dg = 9;
         r += dg * w;
         w *= 10;
      end
      return r;
   endfunction

   function automatic logic [4*D-1:0] to_bcd(input int n);
      logic [4*D-1:0] r;
      r = '0;
      for (int i = 0; i < D; i++) begin
         r[4*i +: 4] = 4'(n % 10);
         n = n / 10;
      end
      return r;
   endfunction

   function automatic int term_val(input bit up);
      return up ? MODV - 1 : 0;
   endfunction

   task automatic model_edge();
      int st0;
      st0  = m_st;
      m_tc = 1'b0;
      if (reset) begin
         m_st = MI; m_cnt = 0; m_psc = 0; m_up = 1'b1;
      end else if (bus.clear) begin
         m_st = MI; m_cnt = 0; m_psc = 0;
      end else begin
         if (st0 == MR) begin
            if (m_psc == P - 1) begin
               m_psc = 0;
               m_cnt = m_up ? (m_cnt + 1) % MODV : (m_cnt + MODV - 1) % MODV;
               if (m_cnt == term_val(m_up)) begin
                  m_st = MD; m_tc = 1'b1;
               end
            end else begin
               m_psc++;
            end
         end
         if (bus.load) begin
            if (st0 == MI || st0 == MP) begin
               m_cnt = sat_val(bus.load_value);
               m_psc = 0;
            end
         end else if (bus.start) begin
            if (st0 == MI || st0 == MP) begin
               if (st0 == MI) begin
                  m_up  = bus.dir;
                  m_psc = 0;
               end
               if (m_cnt == term_val(m_up)) begin
                  m_st = MD; m_tc = 1'b1; m_psc = 0;
               end else begin
                  m_st = MR;
               end
            end
         end else if (bus.pause && st0 == MR) begin
            m_st = MP; m_tc = 1'b0;
         end
      end
   endtask

   task automatic tick();
      @(posedge clock);
      model_edge();
      #1;
      check("dout", bus.dout, to_bcd(m_cnt));
      check("busy", bus.busy, (m_st == MR));
      check("done", bus.done, (m_st == MD));
      check("tc",   bus.tc,   m_tc);
      @(negedge clock);
      bus.start = 1'b0;
      bus.pause = 1'b0;
      bus.clear = 1'b0;
      bus.load  = 1'b0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      reset = 1'b1;
      bus.start = 1'b0; bus.pause = 1'b0; bus.clear = 1'b0; bus.load = 1'b0;
      bus.dir = 1'b1; bus.load_value = '0;
      run(2);
      reset = 1'b0;
      check("reset_dout", bus.dout, 16'h0000);
      check("reset_busy", bus.busy, 1'b0);

      // count up from zero
      bus.dir = 1'b1; bus.start = 1'b1; tick();
      check("busy_after_start", bus.busy, 1'b1);
      run(3);
      check("before_first_step", bus.dout, 16'h0000);
      tick();
      check("first_step", bus.dout, 16'h0001);
      run(4);
      check("second_step", bus.dout, 16'h0002);

      // full carry and load ignored in RUN
      bus.clear = 1'b1; tick();
      bus.load = 1'b1; bus.load_value = 16'h0998; tick();
      bus.dir = 1'b1; bus.start = 1'b1; tick();
      run(4);
      check("step_0999", bus.dout, 16'h0999);
      run(4);
      check("carry_1000", bus.dout, 16'h1000);
      bus.load = 1'b1; bus.load_value = 16'h1234; tick();
      run(3);
      check("step_1001", bus.dout, 16'h1001);

      // count down to terminal zero
      bus.clear = 1'b1; tick();
      bus.load = 1'b1; bus.load_value = 16'h0003; tick();
      bus.dir = 1'b0; bus.start = 1'b1; tick();
      run(8);
      check("down_0001", bus.dout, 16'h0001);
      run(4);
      check("down_term_dout", bus.dout, 16'h0000);
      check("down_term_tc", bus.tc, 1'b1);
      check("down_term_done", bus.done, 1'b1);
      check("down_term_busy", bus.busy, 1'b0);
      run(20);
      check("done_hold_dout", bus.dout, 16'h0000);
      check("done_hold_done", bus.done, 1'b1);
      check("done_hold_tc", bus.tc, 1'b0);
      bus.clear = 1'b1; tick();
      check("clear_from_done", bus.done, 1'b0);

      // pause mid-period and resume
      bus.dir = 1'b1; bus.start = 1'b1; tick();
      run(4);
      tick();
      bus.pause = 1'b1; tick();
      run(50);
      check("paused_dout", bus.dout, 16'h0001);
      check("paused_busy", bus.busy, 1'b0);
      bus.start = 1'b1; tick();
      tick();
      check("resume_no_step", bus.dout, 16'h0001);
      tick();
      check("resume_step", bus.dout, 16'h0002);

      // saturating load, clear beats load
      bus.clear = 1'b1; tick();
      bus.load = 1'b1; bus.load_value = 16'h9A5F; tick();
      check("load_sat", bus.dout, 16'h9959);
      bus.clear = 1'b1; bus.load = 1'b1; bus.load_value = 16'h1111; tick();
      check("clear_over_load", bus.dout, 16'h0000);

      // terminal step coinciding with pause, then start completes
      bus.load = 1'b1; bus.load_value = 16'h9998; tick();
      bus.dir = 1'b1; bus.start = 1'b1; tick();
      run(3);
      bus.pause = 1'b1; tick();
      check("pause_term_dout", bus.dout, 16'h9999);
      check("pause_term_tc", bus.tc, 1'b0);
      check("pause_term_done", bus.done, 1'b0);
      bus.start = 1'b1; tick();
      check("start_at_term_done", bus.done, 1'b1);
      check("start_at_term_tc", bus.tc, 1'b1);
      tick();
      check("tc_one_cycle", bus.tc, 1'b0);

      // reset mid-run
      bus.clear = 1'b1; tick();
      bus.dir = 1'b1; bus.start = 1'b1; tick();
      run(6);
      reset = 1'b1; tick(); reset = 1'b0;
      check("rst_dout", bus.dout, 16'h0000);
      check("rst_busy", bus.busy, 1'b0);

      // randomized commands against the model
      for (int k = 0; k < 4000; k++) begin
         int r;
         int v;
         r = int'($urandom_range(0, 99));
         if (r < 3)       bus.clear = 1'b1;
         else if (r < 8)  bus.load  = 1'b1;
         else if (r < 14) bus.start = 1'b1;
         else if (r < 18) bus.pause = 1'b1;
         if ($urandom_range(0, 39) == 0) bus.clear = 1'b1;
         bus.dir = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0: begin v = int'($urandom_range(0, 3)); bus.load_value = to_bcd(v); end
            1: begin v = MODV - 1 - int'($urandom_range(0, 3)); bus.load_value = to_bcd(v); end
            default: bus.load_value = 16'($urandom);
         endcase
         reset = ($urandom_range(0, 499) == 0);
         tick();
         reset = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/bcd_timer_ctrl.md
# bcd_timer_ctrl

Controller that sequences a cascaded multi-digit BCD counter as a start/pause/clear timer. It owns the count-enable prescaler, digit carry/borrow ripple, preset loading and terminal-count detection. It sits between user command pulses (buttons or a host register) and the BCD display/readout path. Each digit behaves as the 0–9 wrapping counter the team already uses, extended with direction, enable and load under FSM control.

## Interface
- DIGITS, default 4: number of BCD digits; legal range 1–8.
- PRESCALE, default 10: clock cycles per count step, minimum 1.
- clock  input  1  rising-edge system clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  command pulse: begin or resume counting.
- pause  input  1  command pulse: freeze counting.
- clear  input  1  command pulse: return to IDLE with count zero.
- load  input  1  command pulse: preset the count from load_value.
- load_value  input  4*DIGITS  preset value; digit 0 is in bits [3:0].
- dir  input  1  1 = count up, 0 = count down; sampled only on start from IDLE.
- dout  output  4*DIGITS  current BCD count.
- busy  output  1  high while in RUN.
- done  output  1  high while in DONE.
- tc  output  1  one-cycle pulse on the step that reaches the terminal value.

## Operation
- States: IDLE, RUN, PAUSED, DONE.
- Reset sets state to IDLE, dout to 0, the prescaler to 0 and the latched direction to up. busy, done and tc are 0.
- Command priority within one cycle: clear > load > start > pause. Lower-priority commands in the same cycle are ignored.
- clear, from any state: go to IDLE, set dout to 0 and the prescaler to 0.
- load:
  - Accepted only in IDLE or PAUSED; ignored in RUN and DONE.
  - dout takes load_value, with any digit above 9 forced to 9.
  - State is unchanged and the prescaler is cleared.
- start:
  - From IDLE: latch dir, clear the prescaler, go to RUN.
  - From PAUSED: go to RUN; the prescaler keeps its value and the latched direction is unchanged.
  - Ignored in RUN and DONE.
- pause: RUN goes to PAUSED; ignored in every other state.
- Prescaler behaviour:
  - In RUN it counts 0..PRESCALE-1 and wraps.
  - A step occurs in the cycle where the prescaler equals PRESCALE-1.
  - It holds in PAUSED and is 0 in IDLE and DONE.
- Up step: digit 0 increments. A digit at 9 wraps to 0 and carries into the next digit, rippling combinationally in the same cycle.
- Down step: digit 0 decrements. A digit at 0 wraps to 9 and borrows from the next digit.
- Terminal value is all nines for up and all zeros for down.
  - On a step whose result equals the terminal value: set dout to that value, pulse tc, go to DONE.
  - DONE holds dout; only clear or reset leave it.
- Start from IDLE when dout already equals the terminal value for the sampled dir: go directly to DONE with tc pulsed, with no step taken.
- busy = (state == RUN); done = (state == DONE). All outputs are registered.

## Timing
- Command sampled at edge N; the new state and dout are visible after edge N.
- Steps after a start from IDLE:
  - First step lands at edge N+PRESCALE.
  - Later steps follow every PRESCALE cycles.
  - With PRESCALE = 1, every RUN cycle is a step.
- tc is high for exactly the cycle after the terminal step edge, coincident with done first rising.
- Pause on the same edge as a step: the step is taken (dout updates) and the state becomes PAUSED.
- Clear on the same edge as a terminal step: clear wins; IDLE, dout = 0, no tc.
- Reset asserted mid-count overrides everything on the next edge.
- Full carry chain, e.g. 0999→1000 or 1000→0999, completes in one step edge.

## Test plan
- Reset, then start with dir=1, DIGITS=4, PRESCALE=4 → dout steps 0000, 0001, … every 4 cycles; busy=1 from the cycle after start; first step 4 cycles after start.
- Load 0998 in IDLE, start up → steps 0999, 1000 (full carry), 1001; load issued while in RUN is ignored.
- Load 0003, start with dir=0 → steps 0002, 0001, 0000; then tc is high for one cycle, done=1, busy=0 and dout holds 0000 for 20 further cycles; clear → IDLE, 0000.
- Pause after 2 prescaler cycles of a step period, wait 50 cycles, start → dout unchanged while PAUSED; the next step occurs 2 cycles after resume.
- Load 9A5F → dout = 9959; clear and load in the same cycle → dout = 0000, IDLE.
- Up from 9998 with pause and step on the same edge → dout = 9999, state PAUSED, no tc. Then start → DONE with no step, tc pulsed once. Assert reset mid-RUN → all outputs 0 on the next edge.
